// File: rtl/io_pad_rx_conditioner_pkg.sv
// Shared types and width helpers for the pad receive conditioner.
package io_pad_rx_conditioner_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_RUN   = 1'b1
  } blank_state_e;

  // Bits needed to hold values 0..max_val, never less than one bit.
  function automatic int width_of(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/io_glitch_filter.sv
// One receive channel: synchroniser chain, stability counter and edge pulses.
module io_glitch_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic blank,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  // The raw pad line goes straight into the first flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], din};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= 1'b0;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (blank) begin
        level <= s;
        cnt   <= '0;
      end else if (s == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        level <= s;
        cnt   <= '0;
        rise  <= s;
        fall  <= ~s;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/io_pad_rx_conditioner.sv
// Pad receive front end: per-channel filters plus output blanking after a
// func_select change or reset.
module io_pad_rx_conditioner
  import io_pad_rx_conditioner_pkg::*;
#(
  parameter int TXCOUNT     = 2,
  parameter int RXCOUNT     = 2,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter int SETTLE      = 8,
  localparam int MUXWIDTH   = $clog2(TXCOUNT + RXCOUNT)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [MUXWIDTH-1:0] func_select,
  input  logic [RXCOUNT-1:0]  func_receive,
  output logic [RXCOUNT-1:0]  rx_level,
  output logic [RXCOUNT-1:0]  rx_rise,
  output logic [RXCOUNT-1:0]  rx_fall,
  output logic                rx_valid
);

  localparam int SCW = width_of(SETTLE - 1);
  localparam logic [SCW-1:0] SETTLE_MAX = SCW'(SETTLE - 1);

  generate
    if (TXCOUNT < 1 || RXCOUNT < 1 || SYNC_STAGES < 2 || FILTER_LEN < 1 || SETTLE < 1) begin : g_bad_param
      $error("io_pad_rx_conditioner: parameter out of range");
    end
  endgenerate

  blank_state_e        state, state_d;
  logic [SCW-1:0]      settle_cnt, settle_cnt_d;
  logic [MUXWIDTH-1:0] sel_q;
  logic                sel_vld;
  logic                change;
  logic                blank;

  // sel_q holds no real selection until the first clock after reset.
  assign change = sel_vld && (sel_q != func_select);
  assign blank  = (state == ST_BLANK) || change;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_BLANK;
      settle_cnt <= SETTLE_MAX;
      sel_q      <= '0;
      sel_vld    <= 1'b0;
      rx_valid   <= 1'b0;
    end else begin
      state      <= state_d;
      settle_cnt <= settle_cnt_d;
      sel_q      <= func_select;
      sel_vld    <= 1'b1;
      rx_valid   <= (state_d == ST_RUN);
    end
  end

  always_comb begin
    state_d      = state;
    settle_cnt_d = settle_cnt;
    if (change) begin
      state_d      = ST_BLANK;
      settle_cnt_d = SETTLE_MAX;
    end else if (state == ST_BLANK) begin
      if (settle_cnt == '0) state_d = ST_RUN;
      else                  settle_cnt_d = settle_cnt - 1'b1;
    end
  end

  for (genvar i = 0; i < RXCOUNT; i++) begin : g_ch
    io_glitch_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN)
    ) u_filter (
      .clk   (clk),
      .rst   (rst),
      .blank (blank),
      .din   (func_receive[i]),
      .level (rx_level[i]),
      .rise  (rx_rise[i]),
      .fall  (rx_fall[i])
    );
  end

endmodule

// File: tb/tb_io_pad_rx_conditioner.sv
// Bench for io_pad_rx_conditioner: default build plus a FILTER_LEN=1/SETTLE=1
// build driven in parallel, both checked against a window-based reference model.
module tb_io_pad_rx_conditioner;

  localparam int RX   = 2;
  localparam int S    = 2;
  localparam int MW   = 2;
  localparam int W1   = 1 + 3 * RX;
  localparam int MAXN = 4096;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [MW-1:0] func_select = 2'd1;
  logic [RX-1:0] func_receive = '0;

  logic [RX-1:0] lvl0, rise0, fall0, lvl1, rise1, fall1;
  logic          val0, val1;

  always #5 clk = ~clk;

  io_pad_rx_conditioner #(
    .TXCOUNT(2), .RXCOUNT(RX), .SYNC_STAGES(S), .FILTER_LEN(4), .SETTLE(8)
  ) u_main (
    .clk(clk), .rst(rst), .func_select(func_select), .func_receive(func_receive),
    .rx_level(lvl0), .rx_rise(rise0), .rx_fall(fall0), .rx_valid(val0)
  );

  io_pad_rx_conditioner #(
    .TXCOUNT(2), .RXCOUNT(RX), .SYNC_STAGES(S), .FILTER_LEN(1), .SETTLE(1)
  ) u_fl1 (
    .clk(clk), .rst(rst), .func_select(func_select), .func_receive(func_receive),
    .rx_level(lvl1), .rx_rise(rise1), .rx_fall(fall1), .rx_valid(val1)
  );

  logic [2*W1-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  // Reference model state: input history per edge since reset release.
  logic [RX-1:0] din_h[MAXN];
  logic [MW-1:0] sel_h[MAXN];
  bit            blank_h[2][MAXN];
  int            n;
  int            last_ev[2];
  bit            valid_m[2];
  logic [RX-1:0] lvl_m[2];

  function automatic int fl_of(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic int settle_of(input int i);
    return (i == 0) ? 8 : 1;
  endfunction

  // Synchronised level that the filter sees at edge idx.
  function automatic logic s_at(input int idx, input int c);
    if (idx - S < 1) return 1'b0;
    return din_h[idx-S][c];
  endfunction

  task automatic model_reset();
    n = 0;
    for (int i = 0; i < 2; i++) begin
      last_ev[i] = 0;
      valid_m[i] = 1'b0;
      lvl_m[i]   = '0;
    end
  endtask

  task automatic step(input logic [RX-1:0] d, input logic [MW-1:0] sel);
    logic [W1-1:0] ew[2];
    logic [RX-1:0] r, f;
    bit            chg, blank, acc;
    logic          sv;
    @(negedge clk);
    func_receive = d;
    func_select  = sel;
    n++;
    din_h[n] = d;
    sel_h[n] = sel;
    chg = (n > 1) && (sel_h[n] != sel_h[n-1]);
    for (int i = 0; i < 2; i++) begin
      blank = chg || !valid_m[i];
      blank_h[i][n] = blank;
      if (chg) last_ev[i] = n;
      valid_m[i] = !chg && (n - last_ev[i] >= settle_of(i));
      r = '0;
      f = '0;
      for (int c = 0; c < RX; c++) begin
        sv = s_at(n, c);
        if (blank) begin
          lvl_m[i][c] = sv;
        end else begin
          // Accept when the last FILTER_LEN unblanked samples all oppose the level.
          acc = 1'b1;
          for (int k = 0; k < fl_of(i); k++)
            if (n - k < 1 || blank_h[i][n-k] || s_at(n - k, c) == lvl_m[i][c]) acc = 1'b0;
          if (acc) begin
            lvl_m[i][c] = sv;
            r[c] = sv;
            f[c] = ~sv;
          end
        end
      end
      ew[i] = {valid_m[i], lvl_m[i], r, f};
    end
    exp_q.push_back({ew[1], ew[0]});
    @(posedge clk);
    #2;
  endtask

  task automatic check_zero();
    checks++;
    if ({val0, lvl0, rise0, fall0} != '0) begin
      failures++;
      $display("FAIL reset_main act=%h exp=0", {val0, lvl0, rise0, fall0});
    end
    checks++;
    if ({val1, lvl1, rise1, fall1} != '0) begin
      failures++;
      $display("FAIL reset_fl1 act=%h exp=0", {val1, lvl1, rise1, fall1});
    end
  endtask

  // Called just after a clock edge; release lands in the same phase.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_zero();
    repeat (2) @(posedge clk);
    #1;
    check_zero();
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin : monitor
    logic [2*W1-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({val0, lvl0, rise0, fall0} != e[W1-1:0]) begin
          failures++;
          $display("FAIL out_main t=%0t act=%h exp=%h", $time, {val0, lvl0, rise0, fall0}, e[W1-1:0]);
        end
        checks++;
        if ({val1, lvl1, rise1, fall1} != e[2*W1-1:W1]) begin
          failures++;
          $display("FAIL out_fl1 t=%0t act=%h exp=%h", $time, {val1, lvl1, rise1, fall1}, e[2*W1-1:W1]);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [RX-1:0] d;
    logic [MW-1:0] cur_sel;
    int            hold;
    model_reset();
    @(posedge clk);
    #2;
    do_reset();

    // Settle after reset with select constant.
    for (int i = 0; i < 10; i++) step(2'b00, 2'd1);
    // ch0 step held high.
    for (int i = 0; i < 10; i++) step(2'b01, 2'd1);
    // ch1 high, then low glitches of 1..3 cycles, then a 4-cycle low pulse.
    for (int i = 0; i < 8; i++) step(2'b11, 2'd1);
    for (int len = 1; len <= 4; len++) begin
      for (int i = 0; i < len; i++) step(2'b01, 2'd1);
      for (int i = 0; i < 8; i++) step(2'b11, 2'd1);
    end
    // Select change, then a second change five cycles into blanking.
    for (int i = 0; i < 5; i++) step(2'($urandom_range(0, 3)) | 2'b01, 2'd2);
    for (int i = 0; i < 12; i++) step(2'($urandom_range(0, 3)), 2'd3);
    for (int i = 0; i < 6; i++) step(2'b00, 2'd3);
    // Reset in the middle of an acceptance on ch0.
    for (int i = 0; i < 5; i++) step(2'b01, 2'd3);
    do_reset();
    for (int i = 0; i < 12; i++) step(2'b01, 2'd1);
    // Toggle every two cycles.
    for (int i = 0; i < 16; i++) step((i % 4 < 2) ? 2'b11 : 2'b00, 2'd1);

    cur_sel = 2'd1;
    for (int r = 0; r < 60; r++) begin
      d    = 2'($urandom_range(0, 3));
      hold = $urandom_range(1, 6);
      if ($urandom_range(0, 9) == 0) cur_sel = 2'($urandom_range(0, 3));
      for (int h = 0; h < hold; h++) step(d, cur_sel);
    end

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain act=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
